// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the fetch stage's signals toward execution and instruction memory.
//   redirect_v_i/redirect_pc_i : taken-branch redirect from execution
//   imem_req_o/imem_addr_o     : fetch request and word-aligned address
//   imem_gnt_i                 : request accepted this cycle
//   imem_rvalid_i/imem_rdata_i : in-order instruction response
//   inst_v_o/inst_o/pc_o       : fetched instruction and its PC to execution
// master = fetch unit side, slave = execution/memory side.
interface fetch_unit_if;
    logic        redirect_v_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        inst_v_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;

    modport master (
        input  redirect_v_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output imem_req_o, imem_addr_o, inst_v_o, inst_o, pc_o
    );

    modport slave (
        output redirect_v_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  imem_req_o, imem_addr_o, inst_v_o, inst_o, pc_o
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Issues sequential, pipelined word fetches to instruction memory (at most MAX_OUTSTANDING
// unanswered), pairs each response with its PC through a small PC queue and registers the pair
// toward execution. A redirect from execution squashes everything in flight or buffered.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : fetch_unit_if.master (redirect in, imem request/response, instruction out)
module fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW-1:0] CntMax  = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] PtrLast = PW'(MAX_OUTSTANDING - 1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] dcnt_q, dcnt_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   pc_fifo_q [MAX_OUTSTANDING];
    logic          inst_v_q, inst_v_d;
    logic [31:0]   inst_q, inst_d;
    logic [31:0]   pc_q, pc_d;

    logic req, accept, resp, discard, keep;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    assign req     = !reset && !bus.redirect_v_i && (cnt_q < CntMax);
    assign accept  = req && bus.imem_gnt_i;
    // A response with nothing outstanding is unsolicited and ignored entirely.
    assign resp    = bus.imem_rvalid_i && (cnt_q != '0);
    assign discard = resp && (dcnt_q != '0);
    // Responses landing in a redirect cycle belong to the squashed path.
    assign keep    = resp && (dcnt_q == '0) && !bus.redirect_v_i;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        cnt_d      = cnt_q;
        dcnt_d     = dcnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inst_v_d   = keep;
        inst_d     = inst_q;
        pc_d       = pc_q;

        if (bus.redirect_v_i) begin
            fetch_pc_d = {bus.redirect_pc_i[31:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            // No request in a redirect cycle, so only the response can change cnt. Everything
            // still outstanding afterwards is wrong-path and must be dropped on return.
            cnt_d      = cnt_q - CW'(resp);
            dcnt_d     = cnt_q - CW'(resp);
        end else begin
            cnt_d = cnt_q + CW'(accept) - CW'(resp);
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                wr_ptr_d   = ptr_inc(wr_ptr_q);
            end
            if (discard) begin
                dcnt_d = dcnt_q - 1'b1;
            end
            if (keep) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
                inst_d   = bus.imem_rdata_i;
                pc_d     = pc_fifo_q[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            cnt_q      <= '0;
            dcnt_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inst_v_q   <= 1'b0;
            inst_q     <= '0;
            pc_q       <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            cnt_q      <= cnt_d;
            dcnt_q     <= dcnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inst_v_q   <= inst_v_d;
            inst_q     <= inst_d;
            pc_q       <= pc_d;
        end
    end

    // Queue storage needs no reset: occupancy is tracked by the pointers and counters.
    always_ff @(posedge clk) begin
        if (accept) begin
            pc_fifo_q[wr_ptr_q] <= fetch_pc_q;
        end
    end

    assign bus.imem_req_o  = req;
    assign bus.imem_addr_o = fetch_pc_q;
    // Combinational kill: execution samples the instruction at the same edge its redirect acts.
    assign bus.inst_v_o    = inst_v_q && !bus.redirect_v_i && !reset;
    assign bus.inst_o      = inst_q;
    assign bus.pc_o        = pc_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage feeding the execution stage.
- Generates sequential PCs and issues pipelined requests to the instruction memory.
- Returns each fetched instruction with its PC, and accepts the execution stage's branch redirect (pc_v_x/pc_x).
- On a redirect, squashes every instruction that is in flight or already buffered, so that only correct-path instructions reach execution.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered imem requests (legal range 1..4).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- redirect_v_i  input  1  taken branch from execution (pc_v_x)
- redirect_pc_i  input  32  branch target (pc_x)
- imem_req_o  output  1  fetch request valid
- imem_addr_o  output  32  fetch address, word aligned
- imem_gnt_i  input  1  request accepted this cycle when imem_req_o=1
- imem_rvalid_i  input  1  response valid; responses return in request order, at least 1 cycle after grant
- imem_rdata_i  input  32  instruction word
- inst_v_o  output  1  instruction valid to execution (inst_v_i)
- inst_o  output  32  instruction (inst_i)
- pc_o  output  32  PC of inst_o (pc_i)

Behaviour:
- Clock and reset: clk is the clock; reset is synchronous, active-high.
- State under reset:
  - fetch_pc=RESET_PC.
  - Outstanding count cnt=0 and discard count dcnt=0.
  - PC queue (depth MAX_OUTSTANDING) empty.
  - Output register inst_v_q=0.
  - Consequently imem_req_o=0 and inst_v_o=0 while reset is high.
  - inst_o and pc_o are don't-care while inst_v_o=0.
- Request issue:
  - imem_req_o = !reset & !redirect_v_i & (cnt < MAX_OUTSTANDING).
  - imem_addr_o = fetch_pc.
  - The request is held, with a stable address, until granted.
- On accept (req&gnt): fetch_pc += 4 (wraps modulo 2^32), push imem_addr_o into the PC queue, cnt increments.
- Response:
  - On imem_rvalid_i, cnt decrements; simultaneous accept and response leave cnt unchanged.
  - If dcnt>0, the response is discarded, dcnt decrements, and the PC queue is not popped.
  - Otherwise pop the PC queue and register {pc, rdata} into the output, with inst_v_q=1 next cycle. Latency is rvalid at cycle N -> inst_v_o at N+1.
  - inst_v_q=0 in any cycle with no kept response.
  - The consumer never stalls, so the output register is overwritten every cycle.
- Output gating: inst_v_o = inst_v_q & !redirect_v_i. This is a combinational kill, because execution samples inst_v_i at the same edge its redirect is valid.
- Redirect (redirect_v_i=1), effective at the clock edge:
  - fetch_pc <= {redirect_pc_i[31:2], 2'b00}.
  - The PC queue is flushed.
  - dcnt <= cnt - imem_rvalid_i.
  - Any response arriving in the redirect cycle is dropped, and inst_v_q <= 0.
  - No request is issued in the redirect cycle; the target is requested from the next cycle.
- Back-to-back redirects: the later one wins; dcnt is recomputed from the current cnt.
- Unsolicited response (imem_rvalid_i with cnt=0): ignored, with no state change.
- Reset mid-operation: all counters, queue and output are cleared. The memory is reset in the same cycle, so no response arrives for pre-reset requests.
- Invariant: dcnt + queue occupancy == cnt at all times.
- Sizing: cnt and dcnt are $clog2(MAX_OUTSTANDING+1) bits.

Test Plan:
- Straight-line, gnt=1, 1-cycle response latency, MAX_OUTSTANDING=2 -> one request per cycle at addresses 0,4,8,...; inst_v_o high every cycle from cycle 3 after reset release, with pc_o=0,4,8 in order and inst_o matching memory.
- Memory holds gnt=0 for 3 cycles with address 0x10 pending -> imem_addr_o stays 0x10; no PC skip; the instruction stream resumes at pc_o=0x10 with no duplicates.
- Response latency 4, gnt=1 -> cnt saturates at 2; imem_req_o deasserts while cnt=2; pc_o sequence remains contiguous.
- Redirect to 0x200 while 2 requests (0x08, 0x0C) are outstanding and inst_v_q holds 0x04 -> inst_v_o=0 in the redirect cycle; the next 2 responses are discarded; first valid output is pc_o=0x200; 0x04, 0x08 and 0x0C never appear.
- Redirect with target 0x203, and the same-cycle response case -> fetch address 0x200; the response in the redirect cycle is dropped; dcnt=cnt-1.
- Reset asserted with 2 requests outstanding, then released -> next request is at RESET_PC; no stale instruction is output; cnt=0.
